// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester round-robin writeback arbiter for the register file write port
// Optional same-cycle bypass when both queues are empty: define RF_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_sel,
  input  logic [DW-1:0] req0_dat,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_sel,
  input  logic [DW-1:0] req1_dat,
  output logic          WEN,
  output logic [AW-1:0] wsel,
  output logic [DW-1:0] wdat,
  input  logic [AW-1:0] rsel1,
  input  logic [AW-1:0] rsel2,
  output logic          busy1,
  output logic          busy2,
  output logic          grant
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] sel_q [2][DEPTH];
  logic [AW-1:0] sel_d [2][DEPTH];
  logic [DW-1:0] dat_q [2][DEPTH];
  logic [DW-1:0] dat_d [2][DEPTH];
  logic [PW-1:0] rptr_q [2];
  logic [PW-1:0] rptr_d [2];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] wptr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic          rr_last_q, rr_last_d;

  logic [1:0]    in_valid;
  logic [AW-1:0] in_sel [2];
  logic [DW-1:0] in_dat [2];
  logic [1:0]    ready, live, elig, byp, pop, enq;
  logic          from_fifo, wen_c, gnt_c;

  assign in_valid  = {req1_valid, req0_valid};
  assign in_sel[0] = req0_sel;
  assign in_sel[1] = req1_sel;
  assign in_dat[0] = req0_dat;
  assign in_dat[1] = req1_dat;

  // ready depends on stored count only, so a full queue never accepts on the cycle it drains
  always_comb begin
    ready = 2'b00;
    live  = 2'b00;
    elig  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ready[i] = !rst && (cnt_q[i] < FULL_CNT);
      live[i]  = in_valid[i] && ready[i] && (in_sel[i] != '0);
      elig[i]  = !rst && (cnt_q[i] != '0);
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  always_comb begin
    wen_c     = 1'b0;
    gnt_c     = 1'b0;
    from_fifo = 1'b0;
    byp       = 2'b00;
    if (elig == 2'b11) begin
      wen_c     = 1'b1;
      from_fifo = 1'b1;
      gnt_c     = !rr_last_q;
    end else if (elig != 2'b00) begin
      wen_c     = 1'b1;
      from_fifo = 1'b1;
      gnt_c     = elig[1];
    end
`ifdef RF_WB_BYPASS_EN
    else if (live != 2'b00) begin
      wen_c      = 1'b1;
      gnt_c      = (live == 2'b11) ? !rr_last_q : live[1];
      byp[gnt_c] = 1'b1;
    end
`endif
  end

  always_comb begin
    wsel = '0;
    wdat = '0;
    if (from_fifo) begin
      wsel = sel_q[gnt_c][rptr_q[gnt_c]];
      wdat = dat_q[gnt_c][rptr_q[gnt_c]];
    end else if (byp != 2'b00) begin
      wsel = in_sel[gnt_c];
      wdat = in_dat[gnt_c];
    end
  end

  assign WEN   = wen_c;
  assign grant = wen_c & gnt_c;

  always_comb begin
    sel_d     = sel_q;
    dat_d     = dat_q;
    pop       = 2'b00;
    enq       = 2'b00;
    rr_last_d = wen_c ? gnt_c : rr_last_q;
    for (int i = 0; i < 2; i++) begin
      pop[i]    = from_fifo && (int'(gnt_c) == i);
      enq[i]    = live[i] && !byp[i];
      rptr_d[i] = rptr_q[i] + PW'(pop[i]);
      wptr_d[i] = wptr_q[i] + PW'(enq[i]);
      cnt_d[i]  = cnt_q[i] + CW'(enq[i]) - CW'(pop[i]);
      if (enq[i]) begin
        sel_d[i][wptr_q[i]] = in_sel[i];
        dat_d[i][wptr_q[i]] = in_dat[i];
      end
    end
  end

  // Entry j is live when its distance from the read pointer is below the count
  always_comb begin
    logic          hit1, hit2;
    logic [PW-1:0] off;
    hit1 = 1'b0;
    hit2 = 1'b0;
    off  = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        off = PW'(j) - rptr_q[i];
        if (elig[i] && ({1'b0, off} < cnt_q[i])) begin
          if (sel_q[i][j] == rsel1) hit1 = 1'b1;
          if (sel_q[i][j] == rsel2) hit2 = 1'b1;
        end
      end
    end
    busy1 = hit1 && (rsel1 != '0);
    busy2 = hit2 && (rsel2 != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_last_q <= 1'b1;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_ff @(posedge clk) begin
    sel_q <= sel_d;
    dat_q <= dat_d;
  end

endmodule
